// File: rtl/rv_dmem_resp.sv
// Data-memory responder: handshaked, fixed-latency load/store slave on a 64-bit-wide RAM.
// Decodes RV64 funct3 into access size and extension, and flags misaligned or illegal accesses.
module rv_dmem_resp #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned Words = 2 ** (ADDR_W - 3);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [63:0]         wdata_q;
    logic [2:0]          funct3_q;
    logic                rsp_valid_q, rsp_valid_d;
    logic [63:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [63:0]         mem [Words];

    logic                accept;
    logic                commit;
    logic [1:0]          size;
    logic [2:0]          off;
    logic                misaligned;
    logic                illegal;
    logic                acc_err;
    logic [7:0]          be_base;
    logic [7:0]          be;
    logic [63:0]         wdata_sh;
    logic [63:0]         rd_word;
    logic [63:0]         rd_sh;
    logic [63:0]         load_val;

    assign req_ready_o = (state_q == StIdle);
    assign accept      = req_valid_i && (state_q == StIdle);
    assign commit      = (state_q == StWait) && (cnt_q == 4'd0);

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    // Access decode on the captured request.
    always_comb begin
        size       = funct3_q[1:0];
        off        = addr_q[2:0];
        misaligned = 1'b0;
        be_base    = 8'h01;
        case (size)
            2'd0: begin misaligned = 1'b0;            be_base = 8'h01; end
            2'd1: begin misaligned = off[0];          be_base = 8'h03; end
            2'd2: begin misaligned = (off[1:0] != 2'd0); be_base = 8'h0F; end
            default: begin misaligned = (off != 3'd0); be_base = 8'hFF; end
        endcase
        illegal  = we_q ? funct3_q[2] : (funct3_q == 3'b111);
        acc_err  = misaligned || illegal;
        be       = be_base << off;
        wdata_sh = wdata_q << {off, 3'b000};
    end

    // Load path: shift the addressed lanes down, then extend by size and funct3[2].
    always_comb begin
        rd_word  = mem[addr_q[ADDR_W-1:3]];
        rd_sh    = rd_word >> {off, 3'b000};
        load_val = rd_sh;
        case (size)
            2'd0: load_val = funct3_q[2] ? {56'd0, rd_sh[7:0]}
                                         : {{56{rd_sh[7]}}, rd_sh[7:0]};
            2'd1: load_val = funct3_q[2] ? {48'd0, rd_sh[15:0]}
                                         : {{48{rd_sh[15]}}, rd_sh[15:0]};
            2'd2: load_val = funct3_q[2] ? {32'd0, rd_sh[31:0]}
                                         : {{32{rd_sh[31]}}, rd_sh[31:0]};
            default: load_val = rd_sh;
        endcase
    end

    // RAM has no reset; an async reset drops state out of StWait so no commit follows.
    always_ff @(posedge clk) begin
        if (commit && we_q && !acc_err) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) begin
                    mem[addr_q[ADDR_W-1:3]][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    state_d = StWait;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err;
                    rsp_rdata_d = (acc_err || we_q) ? 64'd0 : load_val;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 64'd0;
            funct3_q <= 3'd0;
        end else if (accept) begin
            we_q     <= req_we_i;
            addr_q   <= req_addr_i[ADDR_W-1:0];
            wdata_q  <= req_wdata_i;
            funct3_q <= req_funct3_i;
        end
    end

endmodule

// File: tb/tb_rv_dmem_resp.sv
// Randomized bench for rv_dmem_resp against a byte-array memory model.
// Checks latency, handshake stability, extension, error flags and reset abort.
module tb_rv_dmem_resp;

    localparam int unsigned Lat = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic [2:0]  req_funct3_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_rdata_o;
    logic        rsp_err_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_mem [256];

    rv_dmem_resp #(
        .ADDR_W  (12),
        .LATENCY (Lat)
    ) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_funct3_i (req_funct3_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory; updates on legal stores.
    task automatic model_access(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [2:0] f3, output logic [63:0] rd, output logic err);
        int n;
        int a;
        logic [63:0] val;
        n   = 1 << f3[1:0];
        a   = int'(addr[7:0]);
        err = ((int'(addr[2:0]) % n) != 0) || (we ? f3[2] : (f3 == 3'b111));
        rd  = 64'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) model_mem[a + i] = wdata[8*i +: 8];
            end else begin
                val = 64'd0;
                for (int i = 0; i < n; i++) val[8*i +: 8] = model_mem[a + i];
                if (!f3[2] && n < 8 && val[8*n-1]) begin
                    for (int b = 8 * n; b < 64; b++) val[b] = 1'b1;
                end
                rd = val;
            end
        end
    endtask

    task automatic do_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [2:0] f3, input int hold, input bit poke);
        logic [63:0] exp_rd;
        logic        exp_err;
        int          lat;
        bit          got;
        model_access(we, addr, wdata, f3, exp_rd, exp_err);
        @(negedge clk);
        req_we_i     = we;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        req_funct3_i = f3;
        req_valid_i  = 1'b1;
        check_eq("ready_idle", {63'd0, req_ready_o}, 64'd1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid_o) begin
                got = 1'b1;
                lat = k;
            end else begin
                check_eq("ready_wait", {63'd0, req_ready_o}, 64'd0);
            end
        end
        if (!got) begin
            check_eq("rsp_timeout", {63'd0, rsp_valid_o}, 64'd1);
            return;
        end
        check_eq("latency", 64'(lat), 64'(Lat));
        check_eq("rdata", rsp_rdata_o, exp_rd);
        check_eq("err", {63'd0, rsp_err_o}, {63'd0, exp_err});
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                req_valid_i  = h[0] ? 1'b0 : 1'b1;
                req_we_i     = 1'b1;
                req_addr_i   = 64'h8;
                req_funct3_i = 3'd3;
                req_wdata_i  = {$urandom, $urandom};
            end
            @(posedge clk);
            #1;
            check_eq("hold_valid", {63'd0, rsp_valid_o}, 64'd1);
            check_eq("hold_rdata", rsp_rdata_o, exp_rd);
            check_eq("hold_err", {63'd0, rsp_err_o}, {63'd0, exp_err});
            check_eq("hold_ready", {63'd0, req_ready_o}, 64'd0);
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        check_eq("done_valid", {63'd0, rsp_valid_o}, 64'd0);
        check_eq("done_ready", {63'd0, req_ready_o}, 64'd1);
    endtask

    initial begin
        rstn         = 1'b0;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_addr_i   = 64'd0;
        req_wdata_i  = 64'd0;
        req_funct3_i = 3'd0;
        rsp_ready_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", {63'd0, req_ready_o}, 64'd1);
        check_eq("rst_valid", {63'd0, rsp_valid_o}, 64'd0);
        check_eq("rst_rdata", rsp_rdata_o, 64'd0);
        check_eq("rst_err", {63'd0, rsp_err_o}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int w = 0; w < 32; w++) do_txn(1'b1, 64'(w * 8), {$urandom, $urandom}, 3'd3, 0, 1'b0);

        do_txn(1'b1, 64'h10, 64'h1122334455667788, 3'd3, 0, 1'b0);
        do_txn(1'b0, 64'h10, 64'd0, 3'd3, 1, 1'b0);
        do_txn(1'b1, 64'h13, 64'h80, 3'd0, 0, 1'b0);
        do_txn(1'b0, 64'h13, 64'd0, 3'd0, 0, 1'b0);
        do_txn(1'b0, 64'h13, 64'd0, 3'd4, 0, 1'b0);
        do_txn(1'b0, 64'h10, 64'd0, 3'd3, 0, 1'b0);
        do_txn(1'b0, 64'h12, 64'd0, 3'd2, 0, 1'b0);
        do_txn(1'b1, 64'h11, 64'hFFFF, 3'd1, 0, 1'b0);
        do_txn(1'b0, 64'h10, 64'd0, 3'd3, 0, 1'b0);
        do_txn(1'b0, 64'h10, 64'd0, 3'd7, 0, 1'b0);
        do_txn(1'b1, 64'h18, 64'hDEAD, 3'd4, 0, 1'b0);
        do_txn(1'b0, 64'h18, 64'd0, 3'd3, 0, 1'b0);
        do_txn(1'b0, 64'h10, 64'd0, 3'd3, 3, 1'b1);

        // Abort a store mid-flight with reset.
        @(negedge clk);
        req_we_i     = 1'b1;
        req_addr_i   = 64'h20;
        req_wdata_i  = 64'hAA;
        req_funct3_i = 3'd3;
        req_valid_i  = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #2;
        check_eq("abort_ready_rst", {63'd0, req_ready_o}, 64'd1);
        check_eq("abort_valid_rst", {63'd0, rsp_valid_o}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check_eq("abort_no_rsp", {63'd0, rsp_valid_o}, 64'd0);
        end
        do_txn(1'b0, 64'h20, 64'd0, 3'd3, 0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            a[11:8] = 4'd0;
            do_txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                   3'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
